// File: rtl/clk_rst_seq_ctrl.sv
// Reset sequencer and per-channel clock-enable generator.
// Ports: clk, arst_n, start_i, sw_rst_i, div_i -> rst_n_o, ch_en_o, ready_o, state_o.
module clk_rst_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start_i,
  input  logic                    sw_rst_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic                    rst_n_o,
  output logic [NUM_CH-1:0]       ch_en_o,
  output logic                    ready_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [HW-1:0]          hold_q;
  logic [HW-1:0]          hold_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_q;
  logic [NUM_CH-1:0]      hit;

  // Reset release synchroniser: a 1 walks in
  // once arst_n is high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_RESET;
      hold_q  <= '0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rst_q   <= (state_d == ST_IDLE) ||
                 (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RESET: begin
        if (sync_q[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (sw_rst_i) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (sw_rst_i) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sw_rst_i) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (!start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_RESET;
        hold_d  = '0;
      end
    endcase
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] divq_q;
    logic [DIV_W-1:0] div_in;

    assign div_in  = div_i[ch*DIV_W +: DIV_W];
    // A zero ratio parks the channel.
    assign hit[ch] = (divq_q != '0) &&
                     (cnt_q == divq_q - 1'b1);

    // Ratio is only resampled at entry, wrap,
    // or while parked, so mid-period edits wait.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        cnt_q  <= '0;
        divq_q <= '0;
      end else if (state_d == ST_RUN) begin
        if (state_q != ST_RUN || hit[ch] ||
            divq_q == '0) begin
          cnt_q  <= '0;
          divq_q <= div_in;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Decoded from flops only; the state term makes
  // an async reset kill pulses at once.
  assign ch_en_o = (state_q == ST_RUN) ? hit : '0;
  assign rst_n_o = rst_q;
  assign ready_o = (state_q == ST_IDLE) ||
                   (state_q == ST_RUN);
  assign state_o = state_q;

endmodule

// File: tb/tb_clk_rst_seq_ctrl.sv
// Directed bench for clk_rst_seq_ctrl.
// Default parameters; inputs and checks on negedge.
module tb_clk_rst_seq_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start_i;
  logic        sw_rst_i;
  logic [31:0] div_i;
  logic        rst_n_o;
  logic [3:0]  ch_en_o;
  logic        ready_o;
  logic [1:0]  state_o;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_rst_seq_ctrl dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start_i  (start_i),
    .sw_rst_i (sw_rst_i),
    .div_i    (div_i),
    .rst_n_o  (rst_n_o),
    .ch_en_o  (ch_en_o),
    .ready_o  (ready_o),
    .state_o  (state_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Release arst_n at a negedge, then check
  // edges 1..19 of the power-up sequence.
  task automatic power_up(input string tag);
    arst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk({tag, "_rst"}, rst_n_o, 0);
      chk({tag, "_rdy"}, ready_o, 0);
      chk({tag, "_st"}, state_o, (k < 3) ? 0 : 1);
    end
    @(negedge clk);
    chk({tag, "_rst19"}, rst_n_o, 1);
    chk({tag, "_rdy19"}, ready_o, 1);
    chk({tag, "_st19"}, state_o, 2);
  endtask

  // div = {ch3=0, ch2=1, ch1=3, ch0=4}.
  task automatic run_chk(input string tag,
                         input int n);
    logic [3:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = {1'b0, 1'b1,
           (c % 3 == 2), (c % 4 == 3)};
      chk({tag, "_en"}, ch_en_o, e);
      chk({tag, "_st"}, state_o, 3);
    end
  endtask

  initial begin
    logic [3:0] e;
    arst_n   = 1'b0;
    start_i  = 1'b0;
    sw_rst_i = 1'b0;
    div_i    = '0;

    // 1: power-up
    repeat (5) @(negedge clk);
    chk("rst_st", state_o, 0);
    chk("rst_rstn", rst_n_o, 0);
    chk("rst_en", ch_en_o, 0);
    chk("rst_rdy", ready_o, 0);
    power_up("pwr");

    // 2: divide ratios
    div_i   = {8'd0, 8'd1, 8'd3, 8'd4};
    start_i = 1'b1;
    run_chk("div", 15);

    // 3: stop with ch0 cnt=2, restart later
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stop_en", ch_en_o, 0);
      chk("stop_st", state_o, 2);
    end
    start_i = 1'b1;
    run_chk("restart", 8);

    // 4: sw reset in RUN with start high
    sw_rst_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sw_rst_i = 1'b0;
      chk("swr_rst", rst_n_o, 0);
      chk("swr_st", state_o, 1);
      chk("swr_en", ch_en_o, 0);
    end
    @(negedge clk);
    chk("swr_idle_rst", rst_n_o, 1);
    chk("swr_idle_st", state_o, 2);
    run_chk("swr_run", 4);

    // 6: ratio change mid-period
    start_i = 1'b0;
    @(negedge clk);
    chk("chg_idle", state_o, 2);
    start_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e = {1'b0, 1'b1, (c % 3 == 2),
           (c >= 3) && (c % 2 == 1)};
      chk("chg_en", ch_en_o, e);
      if (c == 1) div_i[7:0] = 8'd2;
    end
    sw_rst_i = 1'b1;
    @(negedge clk);
    sw_rst_i = 1'b0;
    chk("both_st", state_o, 1);
    chk("both_rst", rst_n_o, 0);
    // restart the hold count partway through
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("hr_st", state_o, 1);
    end
    sw_rst_i = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      sw_rst_i = 1'b0;
      chk("hr2_st", state_o, 1);
      chk("hr2_rst", rst_n_o, 0);
    end
    @(negedge clk);
    chk("hr_idle", state_o, 2);
    @(negedge clk);
    chk("hr_run", state_o, 3);
    chk("hr_run_en", ch_en_o, 4'b0100);

    // 5: async reset between edges
    @(negedge clk);
    chk("pre_arst_en", ch_en_o, 4'b0101);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_rst", rst_n_o, 0);
    chk("arst_en", ch_en_o, 0);
    chk("arst_rdy", ready_o, 0);
    chk("arst_st", state_o, 0);
    start_i = 1'b0;
    @(negedge clk);
    power_up("pwr2");

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
